// File: rtl/miss_victim_ctl_if.sv
// miss_victim_ctl_if: miss request, PLRU/tag lookup, writeback and fill signals of the L1D miss controller
interface miss_victim_ctl_if #(
    parameter int TAG_W = 14
);
    logic             miss_req;
    logic [12:0]      miss_set;
    logic [TAG_W-1:0] miss_tag;
    logic             busy;
    logic [12:0]      lru_ra;
    logic [2:0]       lru_rd;
    logic [3:0]       valid_bits;
    logic [3:0]       dirty_bits;
    logic [4*TAG_W-1:0] tag_rd;
    logic             wb_req;
    logic [12:0]      wb_set;
    logic [TAG_W-1:0] wb_tag;
    logic [1:0]       wb_way;
    logic             wb_ack;
    logic             fill_req;
    logic [12:0]      fill_set;
    logic [TAG_W-1:0] fill_tag;
    logic [1:0]       fill_way;
    logic             fill_ack;
    logic             done;
    logic [3:0]       done_way;
    modport master (
        input  miss_req, miss_set, miss_tag, lru_rd, valid_bits, dirty_bits, tag_rd, wb_ack, fill_ack,
        output busy, lru_ra, wb_req, wb_set, wb_tag, wb_way, fill_req, fill_set, fill_tag, fill_way, done, done_way
    );
    modport slave (
        output miss_req, miss_set, miss_tag, lru_rd, valid_bits, dirty_bits, tag_rd, wb_ack, fill_ack,
        input  busy, lru_ra, wb_req, wb_set, wb_tag, wb_way, fill_req, fill_set, fill_tag, fill_way, done, done_way
    );
endinterface

// File: rtl/miss_victim_ctl.sv
// miss_victim_ctl: PLRU victim selection with writeback and fill sequencing for the L1D miss path
module miss_victim_ctl #(
    parameter int TAG_W = 14
) (
    input logic clk,
    input logic reset,
    miss_victim_ctl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;
    state_t           state, state_n;
    logic [12:0]      set_q;
    logic [TAG_W-1:0] tag_q, vtag_q;
    logic [1:0]       way_q, way_c;
    logic             dirty_c;
    // invalid ways win by lowest index; otherwise walk the PLRU tree away from the MRU side
    always_comb begin
        way_c = !bus.valid_bits[0] ? 2'd0 :
                !bus.valid_bits[1] ? 2'd1 :
                !bus.valid_bits[2] ? 2'd2 :
                !bus.valid_bits[3] ? 2'd3 :
                bus.lru_rd[2] ? (bus.lru_rd[0] ? 2'd0 : 2'd1) : (bus.lru_rd[1] ? 2'd2 : 2'd3);
        dirty_c = bus.valid_bits[way_c] & bus.dirty_bits[way_c];
    end
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = bus.miss_req ? LOOKUP : IDLE;
            LOOKUP:  state_n = dirty_c ? WB : FILL;
            WB:      state_n = bus.wb_ack ? FILL : WB;
            FILL:    state_n = bus.fill_ack ? DONE : FILL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            set_q  <= '0;
            tag_q  <= '0;
            vtag_q <= '0;
            way_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.miss_req) begin
                set_q <= bus.miss_set;
                tag_q <= bus.miss_tag;
            end
            if (state == LOOKUP) begin
                way_q  <= way_c;
                vtag_q <= bus.tag_rd[way_c*TAG_W +: TAG_W];
            end
        end
    end
    assign bus.busy     = state != IDLE;
    assign bus.lru_ra   = set_q;
    assign bus.wb_req   = state == WB;
    assign bus.wb_set   = set_q;
    assign bus.wb_tag   = vtag_q;
    assign bus.wb_way   = way_q;
    assign bus.fill_req = state == FILL;
    assign bus.fill_set = set_q;
    assign bus.fill_tag = tag_q;
    assign bus.fill_way = way_q;
    assign bus.done     = state == DONE;
    assign bus.done_way = (state == DONE) ? (4'b0001 << way_q) : 4'b0000;
endmodule

// File: tb/tb_miss_victim_ctl.sv
// tb_miss_victim_ctl: directed checks of victim choice, writeback/fill handshakes, reset abort and ack filtering
module tb_miss_victim_ctl;
    logic clk = 1'b0;
    logic reset;
    int n_assert = 0;
    int n_fail = 0;
    logic [2:0] lv [4] = '{3'b100, 3'b101, 3'b000, 3'b010};
    int ew [4] = '{1, 0, 3, 2};

    miss_victim_ctl_if #(.TAG_W(14)) bus ();
    miss_victim_ctl #(.TAG_W(14)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input logic [12:0] s, input logic [13:0] t);
        bus.miss_req = 1'b1;
        bus.miss_set = s;
        bus.miss_tag = t;
        tick();
        bus.miss_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.miss_req = 0; bus.miss_set = 0; bus.miss_tag = 0;
        bus.lru_rd = 0; bus.valid_bits = 0; bus.dirty_bits = 0; bus.tag_rd = 0;
        bus.wb_ack = 0; bus.fill_ack = 0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_reqs", {bus.wb_req, bus.fill_req, bus.done}, 0);
        chk("rst_done_way", bus.done_way, 0);
        chk("rst_addr", {bus.lru_ra, bus.wb_set, bus.wb_tag, bus.wb_way, bus.fill_set, bus.fill_tag, bus.fill_way} != 0, 0);

        // invalid way2 chosen despite dirty neighbours, no writeback
        bus.valid_bits = 4'b1011; bus.dirty_bits = 4'b1011; bus.lru_rd = 3'b000;
        bus.tag_rd = {14'h0033, 14'h0022, 14'h0011, 14'h0000};
        miss(13'h0ABC, 14'h2222);
        chk("t1_lookup_busy", bus.busy, 1);
        chk("t1_lru_ra", bus.lru_ra, 13'h0ABC);
        chk("t1_lookup_reqs", {bus.wb_req, bus.fill_req}, 0);
        tick();
        chk("t1_wb_req", bus.wb_req, 0);
        chk("t1_fill_req", bus.fill_req, 1);
        chk("t1_fill_way", bus.fill_way, 2);
        chk("t1_fill_set", bus.fill_set, 13'h0ABC);
        chk("t1_fill_tag", bus.fill_tag, 14'h2222);
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        chk("t1_done", bus.done, 1);
        chk("t1_done_way", bus.done_way, 4'b0100);
        chk("t1_fill_drop", bus.fill_req, 0);
        tick();
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_done_way", bus.done_way, 0);

        // PLRU walk on all-valid clean sets, back-to-back misses
        bus.valid_bits = 4'b1111; bus.dirty_bits = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.lru_rd = lv[i];
            miss(13'h0100 + 13'(i), 14'h0100 + 14'(i));
            tick();
            chk($sformatf("t2_fill_req_%0d", i), bus.fill_req, 1);
            chk($sformatf("t2_fill_way_%0d", i), bus.fill_way, ew[i]);
            bus.fill_ack = 1'b1;
            tick();
            bus.fill_ack = 1'b0;
            chk($sformatf("t2_done_way_%0d", i), bus.done_way, 4'b0001 << ew[i]);
            tick();
            chk($sformatf("t2_idle_%0d", i), bus.busy, 0);
        end

        // dirty way3 writeback with 5-cycle ack delay, stray miss_req pulses ignored
        bus.lru_rd = 3'b000; bus.dirty_bits = 4'b1000;
        bus.tag_rd = {14'h01A5, 14'h0222, 14'h0111, 14'h0000};
        miss(13'h1234, 14'h0777);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_wb_req_%0d", i), bus.wb_req, 1);
            chk($sformatf("t3_fill_req_in_wb_%0d", i), bus.fill_req, 0);
            if (i == 0) begin
                chk("t3_wb_tag", bus.wb_tag, 14'h01A5);
                chk("t3_wb_way", bus.wb_way, 3);
                chk("t3_wb_set", bus.wb_set, 13'h1234);
            end
            bus.miss_req = (i == 2);
            bus.miss_set = 13'h1FFF; bus.miss_tag = 14'h3FFF;
            bus.wb_ack = (i == 4);
            tick();
        end
        bus.wb_ack = 1'b0;
        chk("t3_wb_drop", bus.wb_req, 0);
        chk("t3_fill_req", bus.fill_req, 1);
        chk("t3_fill_way", bus.fill_way, 3);
        bus.miss_req = 1'b1;
        tick();
        bus.miss_req = 1'b0;
        chk("t4_fill_hold", bus.fill_req, 1);
        chk("t4_fill_tag", bus.fill_tag, 14'h0777);
        chk("t4_fill_set", bus.fill_set, 13'h1234);
        chk("t4_no_done", bus.done, 0);
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        chk("t3_done_way", bus.done_way, 4'b1000);
        tick();
        chk("t4_idle_a", {bus.busy, bus.done}, 0);
        tick();
        chk("t4_idle_b", {bus.busy, bus.done}, 0);

        // reset while writeback pending, late ack ignored
        miss(13'h0555, 14'h0999);
        tick();
        chk("t5_wb_req", bus.wb_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_wb_drop", bus.wb_req, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_wb_set", bus.wb_set, 0);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("t5_no_fill", {bus.fill_req, bus.busy, bus.done}, 0);
        tick();
        chk("t5_still_idle", {bus.fill_req, bus.busy, bus.done}, 0);

        // fill_ack held through IDLE and LOOKUP must not complete the fill
        bus.valid_bits = 4'b1110; bus.dirty_bits = 4'b1111;
        bus.fill_ack = 1'b1;
        tick();
        chk("t6_idle_busy", bus.busy, 0);
        miss(13'h0777, 14'h0123);
        chk("t6_lookup_fill", bus.fill_req, 0);
        bus.fill_ack = 1'b0;
        tick();
        chk("t6_fill_req", bus.fill_req, 1);
        chk("t6_fill_way", bus.fill_way, 0);
        chk("t6_no_wb", bus.wb_req, 0);
        tick();
        chk("t6_fill_wait", {bus.fill_req, bus.done}, 2'b10);
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        chk("t6_done", bus.done, 1);
        chk("t6_done_way", bus.done_way, 4'b0001);
        tick();
        chk("t6_idle", {bus.busy, bus.done, bus.done_way}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/miss_victim_ctl.md
# miss_victim_ctl

Miss-handling controller for the 4-way, 8192-set, 32 B-line L1 data cache. On a cache miss it reads the set's pseudo-LRU bits from the LRU/dirty bit regfile, together with the per-way valid, dirty and tag state, and selects a victim way. If the victim is dirty it sequences a writeback, then sequences the line fill. On completion it emits a one-hot way that drives the regfile's `way_hit`/`wr` update and the tag/valid array writes.

## Interface
Parameters:
- `TAG_W`, default 14: tag width (32b address = 14b tag, 13b set, 5b offset).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `miss_req` in 1: miss request; sampled only in IDLE.
- `miss_set` in 13: set index of the missing line.
- `miss_tag` in TAG_W: tag of the missing line.
- `busy` out 1: high in every state except IDLE.
- `lru_ra` out 13: read address to the PLRU regfile; equals the captured set.
- `lru_rd` in 3: PLRU bits {b2,b1,b0} for `lru_ra`, combinational read.
- `valid_bits` in 4: per-way valid for the captured set.
- `dirty_bits` in 4: per-way dirty for the captured set.
- `tag_rd` in 4*TAG_W: per-way tags; way n is `[n*TAG_W +: TAG_W]`.
- `wb_req` out 1, `wb_set` out 13, `wb_tag` out TAG_W, `wb_way` out 2: writeback request and the victim's address/way.
- `wb_ack` in 1: writeback accepted.
- `fill_req` out 1, `fill_set` out 13, `fill_tag` out TAG_W, `fill_way` out 2: fill request.
- `fill_ack` in 1: fill data written; line complete.
- `done` out 1: one-cycle completion pulse.
- `done_way` out 4: one-hot victim way, valid only while `done`=1; otherwise 0.

## Operation
- States: IDLE, LOOKUP, WB, FILL, DONE.
- IDLE:
  - If `miss_req`=1, capture `miss_set`/`miss_tag` and go to LOOKUP.
  - `miss_req` is ignored in every other state. The requester holds off until `done`.
- LOOKUP:
  - `lru_ra` is already the captured set. Sample `lru_rd`, `valid_bits`, `dirty_bits` and `tag_rd` combinationally.
  - Register the victim way, its dirty bit and its tag.
  - Next state: WB if the victim is valid and dirty, else FILL.
- Victim selection (priority order):
  1. Any invalid way: pick the lowest-numbered invalid way.
  2. All valid, `b2`=1: pick way0 if `b0`=1, else way1.
  3. All valid, `b2`=0: pick way2 if `b1`=1, else way3.
  - This mirrors the PLRU update rules: way0/1 access clears b2, way2/3 access sets b2; b0 marks way1 MRU; b1 marks way3 MRU.
- WB:
  - `wb_req`=1 with `wb_set` = captured set, `wb_tag` = victim tag, `wb_way` = victim.
  - Held until `wb_ack`=1 is sampled on a clock edge, then go to FILL.
- FILL:
  - `fill_req`=1 with `fill_set`/`fill_tag` = captured miss set/tag and `fill_way` = victim.
  - Held until `fill_ack`=1, then go to DONE.
- DONE: `done`=1 and `done_way` = one-hot victim for exactly one cycle, then go to IDLE.
- Acks outside their matching state are ignored. Acks are never queued.
- Request address outputs are registered and stable for the whole time their request is high.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `wb_req`, `fill_req`, `done` = 0.
  - `done_way` = 0.
  - `lru_ra`, `wb_*`, `fill_*` address and way fields = 0.
- Reset mid-operation: at the next edge, return to IDLE with all requests dropped. No `done` is issued. A late ack is ignored.
- An ack may arrive in the first cycle its request is high; the handshake completes at that edge.
- Clean miss, zero-wait fill:
  - `miss_req` sampled at edge T.
  - LOOKUP in cycle T+1.
  - `fill_req` high in cycle T+2, with `fill_ack` in the same cycle.
  - `done` in cycle T+3; `busy`=0 in cycle T+4.
- A dirty victim adds one cycle of WB plus the `wb_ack` wait.
- A new `miss_req` may be accepted in the first IDLE cycle after DONE.

## Test plan
- Set with `valid_bits`=4'b1011, ways 0/1/3 dirty -> victim way2, no `wb_req`; `fill_way`=2; `done_way`=4'b0100 at T+3.
- All valid and clean; `lru_rd` = 3'b100, 3'b101, 3'b000, 3'b010 on four misses -> victim way1, way0, way3, way2 respectively.
- All valid, victim way3 dirty with tag 14'h1A5 -> `wb_req` with `wb_tag`=14'h1A5, `wb_way`=3. `wb_ack` delayed 5 cycles -> `wb_req` stays high exactly 5 cycles, `fill_req` rises the next cycle, then `done`.
- `miss_req` pulsed during WB and FILL -> no effect. Exactly one `done` results, and the captured tag is unchanged.
- `reset` asserted while in WB with `wb_req`=1 -> next cycle IDLE, `wb_req`=0, `busy`=0. A following `wb_ack` produces no `fill_req`.
- `fill_ack` held high in IDLE and during LOOKUP -> ignored. FILL still produces `fill_req` and needs the ack sampled in FILL.
